calc_scheduler: RTL and testbench
=================================

Name: calc_scheduler

Overview:
Sequential front-end that shares one 8-bit add/sub/mul/div calculator datapath between NUM_REQ requesters. It uses round-robin arbitration, a valid/ready handshake per requester and a single response channel tagged with the requester id. Add, sub and mul complete in one execute cycle. Divide runs on an iterative restoring divider. Divide-by-zero is flagged rather than computed.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_W, 8, operand width; result width is 2*DATA_W
ID_W, $clog2(NUM_REQ) (minimum 1), width of rsp_id (derived, localparam)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_a  in  NUM_REQ*DATA_W  first operands, requester i at slice [i*DATA_W +: DATA_W]
req_b  in  NUM_REQ*DATA_W  second operands, same slicing
req_op  in  NUM_REQ*2  opcodes: 00 add, 01 sub, 10 mul, 11 div
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  ID_W  index of the requester that owns the response
rsp_result  out  2*DATA_W  result
rsp_err  out  1  divide-by-zero flag
busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, req_ready 0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_err 0, busy 0, last_grant = NUM_REQ-1 (requester 0 has first priority).
- Reset mid-operation: reset aborts any operation. No response is produced and the divider is cleared.
- FSM states are IDLE, EXEC, DIV and RESP.
- IDLE:
  - Grant goes to the first requester with req_valid=1, searching from last_grant+1 with wrap-around.
  - req_ready[grant] is asserted combinationally in the same cycle. Acceptance = req_valid & req_ready.
  - On acceptance, capture a, b, op and id, and set last_grant = grant.
  - Next state: div with b==0 -> RESP; div with b!=0 -> DIV (start divider); otherwise -> EXEC.
- req_ready is 0 in every state other than IDLE.
- Requesters hold valid and data stable until accepted. Non-granted requesters wait.
- EXEC (1 cycle): compute and register the result, then go to RESP. Width rules:
  - add: zero-extended sum.
  - sub: a-b in 2*DATA_W two's complement, wraps (100-200 = 16'hFF9C).
  - mul: full 2*DATA_W product.
- DIV:
  - calc_divider runs exactly DATA_W cycles.
  - rsp_result = {remainder[DATA_W-1:0], quotient[DATA_W-1:0]}.
  - Go to RESP on divider done.
- Divide-by-zero: rsp_err=1, rsp_result = all ones.
- rsp_err is 0 for all other responses.
- RESP:
  - rsp_valid=1. rsp_id, rsp_result and rsp_err stay stable until rsp_ready=1.
  - The handshake cycle returns to IDLE with rsp_valid=0.
  - A new request is not accepted in the same cycle as the response handshake; the earliest acceptance is the following IDLE cycle.
- Latency (acceptance at edge T):
  - add/sub/mul: rsp_valid first high in cycle T+2.
  - div: T+DATA_W+1.
  - div-by-zero: T+1.
- Throughput: one operation in flight; no buffering.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0.
- rsp_result, rsp_id and rsp_err hold the last response value after the handshake until the next response.

Decomposition:
- Package calc_pkg holds:
  - typedef enum logic [1:0] calc_op_e {OP_ADD, OP_SUB, OP_MUL, OP_DIV};
  - typedef enum sched_state_e {IDLE, EXEC, DIV, RESP};
  - function next_rr_grant(req, last).
- Sub-module calc_divider (parameter DATA_W):
  - Restoring shift-subtract divider.
  - Ports: clk, rst_n, start, dividend, divisor, done (1-cycle pulse), quotient, remainder.
  - Exactly DATA_W iterations.
  - Not started when divisor is 0.

Test Plan:
1. req0 add a=200 b=100, rsp_ready=1 -> req_ready[0] high in the acceptance cycle; rsp_valid at T+2 with rsp_result=16'd300, rsp_id=0, rsp_err=0.
2. req1 sub 100-200, then req1 mul 200*100 -> 16'hFF9C, then 16'h4E20; both rsp_id=1; busy high from T+1 until the handshake.
3. req0 div 200/7 -> rsp_valid at T+9, rsp_result=16'h041C (rem 4, quot 28). Separately, 200/100 -> 16'h0002.
4. req1 div 5/0 -> rsp_valid at T+1, rsp_err=1, rsp_result=16'hFFFF, rsp_id=1.
5. Both requesters continuously valid with add ops; rsp_ready low for 5 cycles on the first response:
   - Grants alternate 0,1,0,1.
   - During the stall, outputs stay stable and req_ready stays 0.
6. rst_n pulsed low mid-DIV (cycle T+3):
   - All outputs drop to 0 immediately (asynchronously).
   - No response is produced.
   - After release, with both requesters valid, requester 0 is granted first and served correctly.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and the round-robin helper for the calculator scheduler.
package calc_pkg;

  localparam int MAX_REQ = 8;
  localparam int GID_W   = 3;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} calc_op_e;
  typedef enum logic [1:0] {IDLE, EXEC, DIV, RESP} sched_state_e;

  // First requester at or after last+1 (mod n); returns last when nothing is requesting.
  function automatic logic [GID_W-1:0] next_rr_grant(input logic [MAX_REQ-1:0] req,
                                                     input logic [GID_W-1:0]   last,
                                                     input int                 n);
    logic [GID_W-1:0] g;
    int idx;
    g = last;
    for (int k = MAX_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % n;
      if (k <= n && req[idx]) g = GID_W'(idx);
    end
    return g;
  endfunction

endpackage

// File: rtl/calc_divider.sv
// Restoring shift-subtract divider: first iteration on the start edge, DATA_W in total.
module calc_divider #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] r_rem, r_quo, r_dvs;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy, r_done;

  logic              w_go, w_step;
  logic [DATA_W-1:0] w_rem_in, w_quo_in, w_dvs_in, w_rem_nx, w_quo_nx;
  logic [DATA_W:0]   w_shift, w_diff;
  logic [CNT_W-1:0]  w_cnt_nx;

  assign w_go     = start && (divisor != '0);
  assign w_step   = w_go || r_busy;
  assign w_rem_in = w_go ? '0       : r_rem;
  assign w_quo_in = w_go ? dividend : r_quo;
  assign w_dvs_in = w_go ? divisor  : r_dvs;

  // Partial remainder stays below the divisor, so the borrow bit alone decides restore.
  assign w_shift  = {w_rem_in, w_quo_in[DATA_W-1]};
  assign w_diff   = w_shift - {1'b0, w_dvs_in};
  assign w_rem_nx = w_diff[DATA_W] ? w_shift[DATA_W-1:0] : w_diff[DATA_W-1:0];
  assign w_quo_nx = {w_quo_in[DATA_W-2:0], ~w_diff[DATA_W]};
  assign w_cnt_nx = w_go ? CNT_W'(1) : r_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_step) begin
        r_rem  <= w_rem_nx;
        r_quo  <= w_quo_nx;
        r_dvs  <= w_dvs_in;
        r_cnt  <= w_cnt_nx;
        r_busy <= (w_cnt_nx != CNT_W'(DATA_W));
        r_done <= (w_cnt_nx == CNT_W'(DATA_W));
      end
    end
  end

  assign done      = r_done;
  assign quotient  = r_quo;
  assign remainder = r_rem;

endmodule

// File: rtl/calc_scheduler.sv
// Round-robin front-end sharing one add/sub/mul/div datapath between NUM_REQ requesters.
module calc_scheduler
  import calc_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int DATA_W  = 8,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]      req_op,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [2*DATA_W-1:0]       rsp_result,
  output logic                      rsp_err,
  output logic                      busy
);
  sched_state_e        r_state, w_next;
  logic [ID_W-1:0]     r_last, r_cur_id, r_rsp_id, w_grant;
  logic [DATA_W-1:0]   r_a, r_b, w_a, w_b, w_quo, w_rem;
  calc_op_e            r_op, w_op;
  logic [2*DATA_W-1:0] r_result, w_alu;
  logic                r_err;
  logic [NUM_REQ-1:0]  w_ready;
  logic                w_accept, w_div0, w_div_start, w_div_done;

  assign w_grant = ID_W'(next_rr_grant(MAX_REQ'(req_valid), GID_W'(r_last), NUM_REQ));
  // Gated by rst_n so req_ready reads 0 while reset is held even with requests pending.
  assign w_ready = (r_state == IDLE && |req_valid && rst_n) ? (NUM_REQ'(1) << w_grant) : '0;
  assign w_accept    = |(req_valid & w_ready);
  assign w_a         = req_a[w_grant*DATA_W +: DATA_W];
  assign w_b         = req_b[w_grant*DATA_W +: DATA_W];
  assign w_op        = calc_op_e'(req_op[w_grant*2 +: 2]);
  assign w_div0      = (w_op == OP_DIV) && (w_b == '0);
  assign w_div_start = w_accept && (w_op == OP_DIV) && !w_div0;

  calc_divider #(.DATA_W(DATA_W)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (w_div_start),
    .dividend  (w_a),
    .divisor   (w_b),
    .done      (w_div_done),
    .quotient  (w_quo),
    .remainder (w_rem)
  );

  always_comb begin
    w_alu = '0;
    unique case (r_op)
      OP_ADD:  w_alu = (2*DATA_W)'(r_a) + (2*DATA_W)'(r_b);
      OP_SUB:  w_alu = (2*DATA_W)'(r_a) - (2*DATA_W)'(r_b);
      OP_MUL:  w_alu = (2*DATA_W)'(r_a) * (2*DATA_W)'(r_b);
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = (w_op != OP_DIV) ? EXEC : (w_div0 ? RESP : DIV);
      EXEC:    w_next = RESP;
      DIV:     if (w_div_done) w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_last   <= ID_W'(NUM_REQ - 1);
      r_cur_id <= '0;
      r_rsp_id <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_ADD;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_last   <= w_grant;
        r_cur_id <= w_grant;
        r_a      <= w_a;
        r_b      <= w_b;
        r_op     <= w_op;
        if (w_div0) begin
          r_result <= '1;
          r_err    <= 1'b1;
          r_rsp_id <= w_grant;
        end
      end
      // Response fields only change on entry to RESP so they hold between responses.
      if (r_state == EXEC) begin
        r_result <= w_alu;
        r_err    <= 1'b0;
        r_rsp_id <= r_cur_id;
      end
      if (r_state == DIV && w_div_done) begin
        r_result <= {w_rem, w_quo};
        r_err    <= 1'b0;
        r_rsp_id <= r_cur_id;
      end
    end
  end

  assign req_ready  = w_ready;
  assign rsp_valid  = (r_state == RESP);
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_result;
  assign rsp_err    = r_err;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_calc_scheduler.sv
// Scoreboard bench for calc_scheduler: randomized and directed requests against an arithmetic model.
module tb_calc_scheduler;
  localparam int N  = 2;
  localparam int DW = 8;
  localparam int IW = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid, req_ready;
  logic [N*DW-1:0]   req_a, req_b;
  logic [N*2-1:0]    req_op;
  logic              rsp_valid, rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [2*DW-1:0]   rsp_result;
  logic              rsp_err, busy;

  typedef struct {
    int          id;
    logic [15:0] res;
    logic        err;
    int          first;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0;
  int   model_last = N - 1;
  int   refill[N];
  int   p_issue = 100, op_mode = 0;
  bit   exp_busy = 1'b0, rand_rdy = 1'b0, prev_v = 1'b0, last_acc = 1'b0;

  calc_scheduler #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain arithmetic on the operands, latency from the op class.
  function automatic exp_t model(input int id, input logic [1:0] op, input logic [7:0] a,
                                 input logic [7:0] b, input int acc_cyc);
    exp_t e;
    e.id  = id;
    e.err = 1'b0;
    case (op)
      2'd0: begin e.res = 16'(int'(a) + int'(b)); e.first = acc_cyc + 2; end
      2'd1: begin e.res = 16'(int'(a) - int'(b)); e.first = acc_cyc + 2; end
      2'd2: begin e.res = 16'(int'(a) * int'(b)); e.first = acc_cyc + 2; end
      default: begin
        if (b == 8'd0) begin
          e.res = 16'hFFFF; e.err = 1'b1; e.first = acc_cyc + 1;
        end else begin
          e.res = {8'(a % b), 8'(a / b)}; e.first = acc_cyc + DW + 1;
        end
      end
    endcase
    return e;
  endfunction

  task automatic issue(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
    req_op[i*2 +: 2]  = op;
    req_valid[i]      = 1'b1;
  endtask

  // One clock: checks at the falling edge, input updates just after the rising edge.
  task automatic tick();
    int  gid, eg;
    bit  acc, hs;
    logic [1:0] op;
    logic [7:0] a, b;
    acc = 1'b0; gid = 0;
    @(negedge clk);
    if (rst_n) begin
      chk("busy", busy, exp_busy);
      if (busy && req_valid != 0) chk("ready_while_busy", req_ready, 0);
      chk("ready_onehot", $onehot0(req_ready), 1);
      if ((req_valid & req_ready) != 0) begin
        for (int i = 0; i < N; i++) if (req_valid[i] & req_ready[i]) gid = i;
        eg = model_last;
        for (int k = N; k >= 1; k--) if (req_valid[(model_last + k) % N]) eg = (model_last + k) % N;
        chk("grant", gid, eg);
        model_last = eg;
        sbq.push_back(model(gid, req_op[gid*2 +: 2], req_a[gid*DW +: DW], req_b[gid*DW +: DW], cyc));
        acc = 1'b1;
      end
      hs = rsp_valid & rsp_ready;
      exp_busy = acc ? 1'b1 : (hs ? 1'b0 : exp_busy);
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    if (acc) req_valid[gid] = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i] && refill[i] > 0 && $urandom_range(0, 99) < p_issue) begin
        op = (op_mode > 3) ? 2'($urandom_range(0, 3)) : 2'(op_mode);
        a  = 8'($urandom);
        b  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
        issue(i, op, a, b);
        refill[i]--;
      end
    end
    if (rand_rdy) rsp_ready = ($urandom_range(0, 99) < 70);
  endtask

  function automatic bit work_left();
    bit w;
    w = (sbq.size() != 0) || busy || (req_valid != 0);
    for (int i = 0; i < N; i++) if (refill[i] > 0) w = 1'b1;
    return w;
  endfunction

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while (work_left() && n < maxc) begin
      tick();
      n++;
    end
    if (n >= maxc) chk("idle_timeout", 1, 0);
  endtask

  // Monitor: every presented response is compared with the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_rsp", rsp_valid, 0);
        end else begin
          if (!prev_v) chk("latency", cyc, sbq[0].first);
          chk("rsp_id", rsp_id, sbq[0].id);
          chk("rsp_result", rsp_result, sbq[0].res);
          chk("rsp_err", rsp_err, sbq[0].err);
          if (rsp_ready) void'(sbq.pop_front());
        end
      end
      prev_v = rsp_valid;
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) refill[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_err", rsp_err, 0);
    rst_n = 1'b1;

    issue(0, 2'd0, 8'd200, 8'd100);  wait_idle(50);
    issue(1, 2'd1, 8'd100, 8'd200);  wait_idle(50);
    issue(1, 2'd2, 8'd200, 8'd100);  wait_idle(50);
    issue(0, 2'd3, 8'd200, 8'd7);    wait_idle(50);
    issue(0, 2'd3, 8'd200, 8'd100);  wait_idle(50);
    issue(1, 2'd3, 8'd5, 8'd0);      wait_idle(50);
    issue(0, 2'd3, 8'd255, 8'd1);    wait_idle(50);
    issue(1, 2'd2, 8'd255, 8'd255);  wait_idle(50);

    // Both requesters continuously valid, first response stalled for 5 cycles.
    op_mode = 0; p_issue = 100; rsp_ready = 1'b0;
    issue(0, 2'd0, 8'($urandom), 8'($urandom));
    issue(1, 2'd0, 8'($urandom), 8'($urandom));
    refill[0] = 2; refill[1] = 2;
    n = 0;
    while (!rsp_valid && n < 30) begin tick(); n++; end
    if (n >= 30) chk("stall_wait_timeout", 1, 0);
    repeat (5) tick();
    rsp_ready = 1'b1;
    wait_idle(100);

    // Random traffic with random back-pressure.
    op_mode = 4; p_issue = 40; rand_rdy = 1'b1;
    refill[0] = 25; refill[1] = 25;
    wait_idle(3000);
    rand_rdy = 1'b0; rsp_ready = 1'b1;
    wait_idle(50);

    // Reset pulsed in the middle of a divide.
    op_mode = 0; p_issue = 100;
    issue(0, 2'd3, 8'd200, 8'd7);
    n = 0;
    last_acc = 1'b0;
    while (!last_acc && n < 20) begin tick(); n++; end
    if (n >= 20) chk("div_accept_timeout", 1, 0);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rsp_result", rsp_result, 0);
    chk("arst_rsp_id", rsp_id, 0);
    chk("arst_rsp_err", rsp_err, 0);
    sbq.delete();
    exp_busy = 1'b0;
    model_last = N - 1;
    issue(0, 2'd0, 8'd11, 8'd22);
    issue(1, 2'd2, 8'd33, 8'd44);
    @(posedge clk);
    #1;
    chk("arst_req_ready", req_ready, 0);
    rst_n = 1'b1;
    wait_idle(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
